// File: rtl/uart_byte_tx.sv
// uart_byte_tx
// UART byte transmitter. One start bit, eight data bits sent LSB first, an
// optional parity bit, and one stop bit. A frame starts on an accepted
// send_en pulse and ends with a one-cycle tx_done pulse. All outputs are
// registered, so tx has no combinational path from any input.

module uart_byte_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PARITY   = 0            // 0 = none, 1 = odd, 2 = even
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_en,
  input  logic [7:0] data_byte,
  input  logic [2:0] baud_set,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // Number of clocks in one bit period for each supported baud rate.
  localparam logic [15:0] CYC_9600   = 16'(CLK_FREQ / 9600);
  localparam logic [15:0] CYC_19200  = 16'(CLK_FREQ / 19200);
  localparam logic [15:0] CYC_38400  = 16'(CLK_FREQ / 38400);
  localparam logic [15:0] CYC_57600  = 16'(CLK_FREQ / 57600);
  localparam logic [15:0] CYC_115200 = 16'(CLK_FREQ / 115200);

  localparam logic HAS_PARITY = (PARITY != 0);
  localparam logic ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] bit_cyc, bit_cyc_nxt;   // bit period latched at accept
  logic [15:0] div_cnt, div_cnt_nxt;   // 0 .. bit_cyc-1 inside the current bit
  logic [2:0]  bit_idx, bit_idx_nxt;   // data bit currently on the line
  logic [7:0]  data_lat, data_lat_nxt; // byte latched at accept
  logic        tx_nxt, busy_nxt, done_nxt;

  logic        bit_end;
  logic        parity_bit;

  // Baud selector decode; unused codes fall back to 9600.
  function automatic logic [15:0] cyc_for(input logic [2:0] sel);
    case (sel)
      3'd1:    return CYC_19200;
      3'd2:    return CYC_38400;
      3'd3:    return CYC_57600;
      3'd4:    return CYC_115200;
      default: return CYC_9600;
    endcase
  endfunction

  // Last clock of the current bit: the divider wraps on the next edge.
  assign bit_end = (div_cnt == (bit_cyc - 16'd1));

  // Parity of the latched byte: odd parity makes the total count of ones odd.
  assign parity_bit = ODD_PARITY ? ~^data_lat : ^data_lat;

  // Next-state and next-output logic; every output value is registered below.
  always_comb begin
    // NOTE: every next-value signal gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt    = state;
    bit_cyc_nxt  = bit_cyc;
    div_cnt_nxt  = div_cnt;
    bit_idx_nxt  = bit_idx;
    data_lat_nxt = data_lat;
    tx_nxt       = tx;
    busy_nxt     = tx_busy;
    done_nxt     = 1'b0;

    // Inside a frame the divider runs continuously and wraps at bit_end.
    if (state != S_IDLE) begin
      div_cnt_nxt = bit_end ? 16'd0 : div_cnt + 16'd1;
    end

    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (send_en) begin
          data_lat_nxt = data_byte;
          bit_cyc_nxt  = cyc_for(baud_set);
          div_cnt_nxt  = 16'd0;
          bit_idx_nxt  = 3'd0;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_nxt      = data_lat[0];
          bit_idx_nxt = 3'd0;
          state_nxt   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            if (HAS_PARITY) begin
              tx_nxt    = parity_bit;
              state_nxt = S_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = S_STOP;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = data_lat[bit_idx + 3'd1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          tx_nxt    = 1'b1;
          state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      default: begin
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to the idle line.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      state    <= S_IDLE;
      bit_cyc  <= 16'd0;
      div_cnt  <= 16'd0;
      bit_idx  <= 3'd0;
      data_lat <= 8'd0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cyc  <= bit_cyc_nxt;
      div_cnt  <= div_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      data_lat <= data_lat_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

endmodule
